// File: rtl/add_sub_iter.sv
// Multi-cycle add/subtract: CHUNK bits per enabled cycle, LSB first, with a registered carry.
// Produces carry/overflow/zero/negative flags, can optionally saturate, and uses valid/ready handshakes.
module add_sub_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  input  logic             control,
  input  logic             signedness,
  input  logic             saturate,
  output logic [WIDTH-1:0] value_out,
  output logic             flag_overflow,
  output logic             flag_carry,
  output logic             flag_zero,
  output logic             flag_negative,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK;
  localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             ctrl_q, ctrl_d, sgn_q, sgn_d, sat_q, sat_d;
  logic [WIDTH-1:0] vout_q, vout_d;
  logic             ovf_q, ovf_d, cy_q, cy_d, z_q, z_d, n_q, n_d;
  logic             ov_q, ov_d;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             ovf_raw;
  logic [WIDTH-1:0] result;

  assign in_ready      = (state_q == IDLE) && EN;
  assign value_out     = vout_q;
  assign flag_overflow = ovf_q;
  assign flag_carry    = cy_q;
  assign flag_zero     = z_q;
  assign flag_negative = n_q;
  assign out_valid     = ov_q;

  // Chunk adder, and the full-width view of the sum including the chunk being added this cycle
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < int'(NUM_CHUNKS); i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    sum_d = sum_q;
    for (int i = 0; i < int'(NUM_CHUNKS); i++) begin
      if (cnt_q == CNT_W'(i)) sum_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end
    if (!sgn_q)
      ovf_raw = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
    else
      ovf_raw = ctrl_q ? ~chunk_sum[CHUNK] : chunk_sum[CHUNK];
    result = sum_d;
    if (sat_q && ovf_raw) begin
      if (!sgn_q) result = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else        result = ctrl_q ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end
  end

  // Next-state and registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    sgn_d   = sgn_q;
    sat_d   = sat_q;
    vout_d  = vout_q;
    ovf_d   = ovf_q;
    cy_d    = cy_q;
    z_d     = z_q;
    n_d     = n_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid && EN) begin
          a_d     = value1;
          b_d     = value2 ^ {WIDTH{control}};
          ctrl_d  = control;
          sgn_d   = signedness;
          sat_d   = saturate;
          carry_d = control;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (EN) begin
          carry_d = chunk_sum[CHUNK];
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NUM_CHUNKS - 1)) begin
            vout_d  = result;
            ovf_d   = ovf_raw;
            cy_d    = chunk_sum[CHUNK];
            z_d     = (result == '0);
            n_d     = result[WIDTH-1];
            ov_d    = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      ctrl_q  <= 1'b0;
      sgn_q   <= 1'b0;
      sat_q   <= 1'b0;
      vout_q  <= '0;
      ovf_q   <= 1'b0;
      cy_q    <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= (state_q == BUSY && EN) ? sum_d : sum_q;
      ctrl_q  <= ctrl_d;
      sgn_q   <= sgn_d;
      sat_q   <= sat_d;
      vout_q  <= vout_d;
      ovf_q   <= ovf_d;
      cy_q    <= cy_d;
      z_q     <= z_d;
      n_q     <= n_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: tb/tb_add_sub_iter.sv
// Directed bench for add_sub_iter: a 32/8 instance and a 16/16 instance, checked against a queued reference model.
module tb_add_sub_iter;

  typedef struct packed {
    logic [31:0] v;
    logic        ovf;
    logic        cy;
    logic        z;
    logic        n;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, in_valid, in_ready, control, signedness, saturate;
  logic [31:0] value1, value2, value_out;
  logic        f_ovf, f_cy, f_z, f_n, out_valid, out_ready;

  logic        b_rst, b_en, b_in_valid, b_in_ready, b_control, b_signedness, b_saturate;
  logic [15:0] b_value1, b_value2, b_value_out;
  logic        b_ovf, b_cy, b_z, b_n, b_out_valid, b_out_ready;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  add_sub_iter #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .EN(en), .in_valid(in_valid), .in_ready(in_ready),
    .value1(value1), .value2(value2), .control(control), .signedness(signedness),
    .saturate(saturate), .value_out(value_out), .flag_overflow(f_ovf), .flag_carry(f_cy),
    .flag_zero(f_z), .flag_negative(f_n), .out_valid(out_valid), .out_ready(out_ready)
  );

  add_sub_iter #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(b_rst), .EN(b_en), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .value1(b_value1), .value2(b_value2), .control(b_control), .signedness(b_signedness),
    .saturate(b_saturate), .value_out(b_value_out), .flag_overflow(b_ovf), .flag_carry(b_cy),
    .flag_zero(b_z), .flag_negative(b_n), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model derived from integer ranges rather than adder bits
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ctrl, input logic sgn, input logic sat);
    exp_t   e;
    longint sa, sb_, rs;
    logic   cy, ovf;
    logic [31:0] r;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    rs  = ctrl ? sa - sb_ : sa + sb_;
    r   = ctrl ? a - b : a + b;
    cy  = ctrl ? (a >= b) : (({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF);
    if (!sgn) ovf = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
    else      ovf = ctrl ? (a < b) : cy;
    if (sat && ovf) begin
      if (!sgn) r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else      r = ctrl ? 32'h0 : 32'hFFFF_FFFF;
    end
    e.v = r; e.ovf = ovf; e.cy = cy; e.z = (r == 32'h0); e.n = r[31];
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for one edge; push the expectation when it is accepted
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic ctrl, input logic sgn, input logic sat);
    int guard = 0;
    while (!in_ready && guard < 50) begin step(); guard++; end
    if (guard >= 50) chk("accept_timeout", 64'(guard), 64'd0);
    value1 = a; value2 = b; control = ctrl; signedness = sgn; saturate = sat;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    value1 = $urandom; value2 = $urandom; control = ~ctrl; saturate = ~sat;
    sb.push_back(model(a, b, ctrl, sgn, sat));
  endtask

  task automatic wait_out(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin step(); lat++; end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_value"}, 64'(value_out), 64'(e.v));
    chk({tag, "_flags"}, 64'({f_ovf, f_cy, f_z, f_n}), 64'({e.ovf, e.cy, e.z, e.n}));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ctrl, input logic sgn, input logic sat);
    int lat;
    issue(a, b, ctrl, sgn, sat);
    wait_out(tag, lat);
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    check_result(tag);
    drain(tag);
  endtask

  initial begin
    int         lat;
    int         bad;
    logic [31:0] hv;
    logic [3:0]  hf;
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; control = 1'b0; signedness = 1'b0; saturate = 1'b0;
    value1 = '0; value2 = '0; out_ready = 1'b0;
    b_rst = 1'b1; b_en = 1'b1; b_in_valid = 1'b0; b_control = 1'b0; b_signedness = 1'b0;
    b_saturate = 1'b0; b_value1 = '0; b_value2 = '0; b_out_ready = 1'b1;
    step(); step();
    rst = 1'b0; b_rst = 1'b0;
    chk("reset_value", 64'(value_out), 64'd0);
    chk("reset_flags_valid", 64'({f_ovf, f_cy, f_z, f_n, out_valid}), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    run_op("uadd_wrap",    32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0);
    run_op("uadd_sat",     32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1);
    run_op("sadd_ovf",     32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    run_op("sadd_sat",     32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
    run_op("ssub_5_3",     32'd5,         32'd3, 1'b1, 1'b0, 1'b0);
    run_op("usub_3_5",     32'd3,         32'd5, 1'b1, 1'b1, 1'b0);
    run_op("usub_sat",     32'd3,         32'd5, 1'b1, 1'b1, 1'b1);
    run_op("sadd_negsat",  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    run_op("ssub_mixed",   32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 1'b0);
    run_op("uadd_rand",    32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0, 1'b1, 1'b0);

    // Back-pressure: result must hold while new operands are offered
    issue(32'd100, 32'd58, 1'b0, 1'b1, 1'b0);
    wait_out("bp", lat);
    chk("bp_latency", 64'(lat), 64'd4);
    hv = value_out; hf = {f_ovf, f_cy, f_z, f_n};
    check_result("bp");
    in_valid = 1'b1; value1 = 32'hAAAA_0000; value2 = 32'h5555; control = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (value_out !== hv || {f_ovf, f_cy, f_z, f_n} !== hf || in_ready !== 1'b0 || out_valid !== 1'b1)
        bad++;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin step(); if (out_valid !== 1'b0) bad++; end
    chk("bp_no_accept", 64'(bad), 64'd0);

    // EN stall after chunk 1: three dead cycles stretch latency to 7
    issue(32'h0F0F_F0F0, 32'h00FF_FF01, 1'b0, 1'b1, 1'b0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      en = !(lat >= 2 && lat <= 4);
      step();
      lat++;
    end
    en = 1'b1;
    chk("stall_latency", 64'(lat), 64'd7);
    check_result("stall");
    drain("stall");

    // Reset in BUSY abandons the operation
    value1 = 32'h1111_1111; value2 = 32'h2222_2222; control = 1'b0; signedness = 1'b1;
    saturate = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy_valid", 64'(out_valid), 64'd0);
    chk("rst_busy_value", 64'(value_out), 64'd0);
    chk("rst_busy_idle", 64'(in_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin step(); if (out_valid !== 1'b0) bad++; end
    chk("rst_busy_no_result", 64'(bad), 64'd0);

    // Single-chunk instance: one-cycle latency
    b_value1 = 16'h8000; b_value2 = 16'hFFFF; b_control = 1'b0; b_signedness = 1'b0;
    b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 50) begin step(); lat++; end
    lat++;
    chk("w16_latency", 64'(lat), 64'd2);
    chk("w16_value", 64'(b_value_out), 64'h7FFF);
    chk("w16_flags", 64'({b_ovf, b_cy, b_z, b_n}), 64'b1100);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Overall watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
